// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, registers
// one operation, captures the ALU result and holds it until the consumer takes it.
module alu_arbiter #(
   parameter int PRIO_FIXED = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [4:0]  req0_shamt,
   input  logic [4:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [4:0]  req1_shamt,
   input  logic [4:0]  req1_op,
   output logic [31:0] alu_srcA,
   output logic [31:0] alu_srcB,
   output logic [4:0]  alu_shamt,
   output logic [4:0]  alu_op,
   input  logic [31:0] alu_ao,
   input  logic        alu_overflow,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_ao,
   output logic        rsp_ovf,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [4:0] OP_MAX = 5'b01110;

   state_t      r_state;
   state_t      w_next;
   logic        r_last_grant;
   logic        w_grant;
   logic        w_idle;
   logic        w_xfer;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [4:0]  r_shamt;
   logic [4:0]  r_op;
   logic        r_id;
   logic        r_rsp_id;
   logic [31:0] r_rsp_ao;
   logic        r_rsp_ovf;
   logic        r_rsp_err;

   // Grant is only meaningful when the chosen requester is valid.
   always_comb begin
      w_grant = 1'b0;
      if (PRIO_FIXED != 0)
         w_grant = ~req0_valid;
      else if (req0_valid && req1_valid)
         w_grant = ~r_last_grant;
      else
         w_grant = ~req0_valid;
   end

   // Reset gates ready so no handshake is offered while reset is held.
   assign w_idle     = (r_state == IDLE) && reset;
   assign req0_ready = w_idle && req0_valid && !w_grant;
   assign req1_ready = w_idle && req1_valid && w_grant;
   assign w_xfer     = req0_ready || req1_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_next = EXEC;
         EXEC:    w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_xfer) r_last_grant <= w_grant;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_shamt <= '0;
         r_op    <= '0;
         r_id    <= 1'b0;
      end else if (w_xfer) begin
         r_a     <= w_grant ? req1_a     : req0_a;
         r_b     <= w_grant ? req1_b     : req0_b;
         r_shamt <= w_grant ? req1_shamt : req0_shamt;
         r_op    <= w_grant ? req1_op    : req0_op;
         r_id    <= w_grant;
      end
   end

   // The ALU settles during EXEC; its result is sampled at the end of that cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_id  <= 1'b0;
         r_rsp_ao  <= '0;
         r_rsp_ovf <= 1'b0;
         r_rsp_err <= 1'b0;
      end else if (r_state == EXEC) begin
         r_rsp_id  <= r_id;
         r_rsp_ao  <= alu_ao;
         r_rsp_ovf <= alu_overflow;
         r_rsp_err <= (r_op > OP_MAX);
      end
   end

   assign alu_srcA  = r_a;
   assign alu_srcB  = r_b;
   assign alu_shamt = r_shamt;
   assign alu_op    = r_op;
   assign rsp_valid = (r_state == RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_ao    = r_rsp_ao;
   assign rsp_ovf   = r_rsp_ovf;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share one
// request stimulus; responses of the round-robin instance go through a scoreboard.
module tb_alu_arbiter;

   typedef struct packed {
      logic        id;
      logic [31:0] ao;
      logic        ovf;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic        id;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [4:0]  op;
      logic [31:0] ao;
      logic        ovf;
      logic        err;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]  req0_shamt, req0_op, req1_shamt, req1_op;
   logic        rsp_ready;

   logic        req0_ready, req1_ready;
   logic [31:0] alu_srcA, alu_srcB, alu_ao;
   logic [4:0]  alu_shamt, alu_op;
   logic        alu_overflow;
   logic        rsp_valid, rsp_id, rsp_ovf, rsp_err;
   logic [31:0] rsp_ao;

   logic        fx_req0_ready, fx_req1_ready;
   logic [31:0] fx_alu_srcA, fx_alu_srcB, fx_alu_ao;
   logic [4:0]  fx_alu_shamt, fx_alu_op;
   logic        fx_alu_overflow;
   logic        fx_rsp_valid, fx_rsp_id, fx_rsp_ovf, fx_rsp_err;
   logic [31:0] fx_rsp_ao;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t sb[$];
   int   glog[$];
   int   flog[$];
   exp_t cur[2];
   vec_t vecs[10];

   // Reference ALU: add/sub with signed overflow, logic ops, shifts; illegal ops return a marker.
   function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [4:0] op);
      logic [31:0] s;
      logic        v;
      v = 1'b0;
      case (op)
         5'd0: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
         5'd1: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
         5'd2: s = a & b;
         5'd3: s = a | b;
         5'd4: s = a ^ b;
         5'd5: s = a << sh;
         5'd6: s = a >> sh;
         default: s = (op > 5'd14) ? 32'hABCDDCBA : a;
      endcase
      return {v, s};
   endfunction

   assign {alu_overflow, alu_ao}       = alu_f(alu_srcA, alu_srcB, alu_shamt, alu_op);
   assign {fx_alu_overflow, fx_alu_ao} = alu_f(fx_alu_srcA, fx_alu_srcB, fx_alu_shamt, fx_alu_op);

   alu_arbiter #(.PRIO_FIXED(0)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_shamt(req0_shamt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_shamt(req1_shamt), .req1_op(req1_op),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_shamt(alu_shamt), .alu_op(alu_op),
      .alu_ao(alu_ao), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ao(rsp_ao),
      .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
   );

   alu_arbiter #(.PRIO_FIXED(1)) dut_fx (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_shamt(req0_shamt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_shamt(req1_shamt), .req1_op(req1_op),
      .alu_srcA(fx_alu_srcA), .alu_srcB(fx_alu_srcB), .alu_shamt(fx_alu_shamt), .alu_op(fx_alu_op),
      .alu_ao(fx_alu_ao), .alu_overflow(fx_alu_overflow),
      .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fx_rsp_id), .rsp_ao(fx_rsp_ao),
      .rsp_ovf(fx_rsp_ovf), .rsp_err(fx_rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Sample handshakes at negedge, then return 1 time unit after the next posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (req0_valid && req0_ready) begin sb.push_back(cur[0]); glog.push_back(0); end
      if (req1_valid && req1_ready) begin sb.push_back(cur[1]); glog.push_back(1); end
      if (req0_valid && fx_req0_ready) flog.push_back(0);
      if (req1_valid && fx_req1_ready) flog.push_back(1);
      if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_rsp: got id %0d ao 0x%h, expected no response", rsp_id, rsp_ao);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            chk("rsp_ao", rsp_ao, e.ao);
            chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      cur[v.id] = '{id: v.id, ao: v.ao, ovf: v.ovf, err: v.err};
      if (v.id == 1'b0) begin
         req0_a = v.a; req0_b = v.b; req0_shamt = v.shamt; req0_op = v.op;
      end else begin
         req1_a = v.a; req1_b = v.b; req1_shamt = v.shamt; req1_op = v.op;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int k;
      int n0;
      drive(v);
      n0 = glog.size();
      if (v.id == 1'b0) req0_valid = 1'b1; else req1_valid = 1'b1;
      k = 0;
      while (glog.size() == n0 && k < 20) begin step(); k++; end
      if (glog.size() == n0) chk("grant_timeout", 32'd0, 32'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 20) begin step(); k++; end
      if (sb.size() != 0) chk("rsp_timeout", sb.size(), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
      chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
      chk({tag, "_rsp_valid"},  {31'd0, rsp_valid},  32'd0);
      chk({tag, "_rsp_id"},     {31'd0, rsp_id},     32'd0);
      chk({tag, "_rsp_ao"},     rsp_ao,              32'd0);
      chk({tag, "_rsp_ovf"},    {31'd0, rsp_ovf},    32'd0);
      chk({tag, "_rsp_err"},    {31'd0, rsp_err},    32'd0);
      chk({tag, "_alu_srcA"},   alu_srcA,            32'd0);
      chk({tag, "_alu_srcB"},   alu_srcB,            32'd0);
      chk({tag, "_alu_shamt"},  {27'd0, alu_shamt},  32'd0);
      chk({tag, "_alu_op"},     {27'd0, alu_op},     32'd0);
      chk({tag, "_fx_rsp_valid"}, {31'd0, fx_rsp_valid}, 32'd0);
      chk({tag, "_fx_req0_ready"}, {31'd0, fx_req0_ready}, 32'd0);
   endtask

   initial begin
      int bg;
      int bf;
      int k;
      vec_t v;

      //                id    a              b             shamt  op      ao             ovf   err
      vecs[0] = '{1'b0, 32'd7,         32'd5,        5'd0,  5'd0,  32'd12,        1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h7FFFFFFF,  32'd1,        5'd0,  5'd0,  32'h80000000,  1'b1, 1'b0};
      vecs[2] = '{1'b1, 32'd1,         32'd2,        5'd0,  5'd31, 32'hABCDDCBA,  1'b0, 1'b1};
      vecs[3] = '{1'b0, 32'd5,         32'd7,        5'd0,  5'd1,  32'hFFFFFFFE,  1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h80000000,  32'd1,        5'd0,  5'd1,  32'h7FFFFFFF,  1'b1, 1'b0};
      vecs[5] = '{1'b1, 32'h0000F0F0,  32'h0000FF00, 5'd0,  5'd2,  32'h0000F000,  1'b0, 1'b0};
      vecs[6] = '{1'b0, 32'd1,         32'd0,        5'd4,  5'd5,  32'h00000010,  1'b0, 1'b0};
      vecs[7] = '{1'b1, 32'h80000000,  32'd0,        5'd31, 5'd6,  32'h00000001,  1'b0, 1'b0};
      vecs[8] = '{1'b0, 32'h00000123,  32'd9,        5'd0,  5'd14, 32'h00000123,  1'b0, 1'b0};
      vecs[9] = '{1'b1, 32'd3,         32'd4,        5'd0,  5'd15, 32'hABCDDCBA,  1'b0, 1'b1};

      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_shamt = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_shamt = '0; req1_op = '0;
      rsp_ready = 1'b1;
      cur[0] = '0; cur[1] = '0;
      #3;
      chk_reset("por");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Single op with 5 cycles of response backpressure
      drive(vecs[0]);
      rsp_ready  = 1'b0;
      req0_valid = 1'b1;
      #1;
      chk("single_ready0_idle", {31'd0, req0_ready}, 32'd1);
      step();
      chk("single_ready0_exec", {31'd0, req0_ready}, 32'd0);
      chk("single_rsp_valid_exec", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("single_rsp_valid_t2", {31'd0, rsp_valid}, 32'd1);
      chk("single_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("single_rsp_ao", rsp_ao, 32'd12);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_ao", rsp_ao, 32'd12);
         chk("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
         chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      end
      chk("bp_no_new_xfer", glog.size(), 32'd1);
      req0_valid = 1'b0;
      rsp_ready  = 1'b1;
      step();
      chk("bp_release_idle", {31'd0, rsp_valid}, 32'd0);
      chk("bp_sb_empty", sb.size(), 32'd0);

      // Table-driven operations
      for (int i = 0; i < 10; i++) begin
         v = vecs[i];
         run_vec(v);
      end

      // Reset pulse while EXEC holds an operation
      v = '{1'b0, 32'd3, 32'd4, 5'd0, 5'd0, 32'd7, 1'b0, 1'b0};
      drive(v);
      req0_valid = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk_reset("exec_rst");
      sb.delete();
      step();
      step();
      reset = 1'b1;
      req0_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end

      // Contention after a fresh reset: both requesters valid continuously
      reset = 1'b0;
      #2;
      reset = 1'b1;
      sb.delete();
      bg = glog.size();
      bf = flog.size();
      drive('{1'b0, 32'd1, 32'd2, 5'd0, 5'd0, 32'd3, 1'b0, 1'b0});
      drive('{1'b1, 32'd10, 32'd20, 5'd0, 5'd0, 32'd30, 1'b0, 1'b0});
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (13) step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 10) begin step(); k++; end
      chk("cont_drain", sb.size(), 32'd0);
      chk("cont_rr_enough", {31'd0, (glog.size() - bg) >= 4}, 32'd1);
      chk("cont_fx_enough", {31'd0, (flog.size() - bf) >= 3}, 32'd1);
      if (glog.size() - bg >= 4) begin
         chk("cont_rr_g0", glog[bg],     32'd0);
         chk("cont_rr_g1", glog[bg + 1], 32'd1);
         chk("cont_rr_g2", glog[bg + 2], 32'd0);
         chk("cont_rr_g3", glog[bg + 3], 32'd1);
      end
      if (flog.size() - bf >= 3) begin
         chk("cont_fx_g0", flog[bf],     32'd0);
         chk("cont_fx_g1", flog[bf + 1], 32'd0);
         chk("cont_fx_g2", flog[bf + 2], 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
